// File: rtl/rx_sbinit.sv
// rx_sbinit: responder half of the sideband SBINIT handshake.
// Answers the partner's done_req with a done_resp, then reports completion or timeout.
module rx_sbinit #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_SBINIT_en,
  input  logic                    i_decoded_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_tx_valid,
  input  logic                    i_falling_edge_busy,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic                    o_valid_rx,
  output logic                    o_SBINIT_end_rx,
  output logic                    o_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, WAIT_OOR, WAIT_DONE_REQ, SEND_DONE_RESP, SBINIT_END, TIMEOUT} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            sent_q;
  logic            seen_oor, seen_req, expire, active;
  assign seen_oor = i_decoded_msg_valid && i_decoded_SB_msg == SB_MSG_WIDTH'(3);
  assign seen_req = i_decoded_msg_valid && i_decoded_SB_msg == SB_MSG_WIDTH'(1);
  assign expire   = cnt_q >= CW'(TIMEOUT_CYCLES - 1);
  assign active   = state_q == WAIT_OOR || state_q == WAIT_DONE_REQ || state_q == SEND_DONE_RESP;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || !i_SBINIT_en) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      sent_q              <= 1'b0;
      o_encoded_SB_msg_rx <= '0;
      o_valid_rx          <= 1'b0;
      o_SBINIT_end_rx     <= 1'b0;
      o_timeout           <= 1'b0;
    end else begin
      if (active && cnt_q != '1) cnt_q <= cnt_q + CW'(1);
      case (state_q)
        IDLE: state_q <= WAIT_OOR;
        WAIT_OOR, WAIT_DONE_REQ: begin
          // done_req alone is enough: it proves the partner is already out of reset
          if (seen_req) begin
            state_q             <= SEND_DONE_RESP;
            o_encoded_SB_msg_rx <= SB_MSG_WIDTH'(2);
            sent_q              <= 1'b0;
          end else if (seen_oor && state_q == WAIT_OOR) begin
            state_q <= WAIT_DONE_REQ;
          end else if (expire) begin
            state_q   <= TIMEOUT;
            o_timeout <= 1'b1;
          end
        end
        SEND_DONE_RESP: begin
          // busy pulses while we are not requesting belong to the transmit FSM
          if (o_valid_rx && i_falling_edge_busy) begin
            state_q         <= SBINIT_END;
            o_valid_rx      <= 1'b0;
            o_SBINIT_end_rx <= 1'b1;
          end else if (expire) begin
            state_q    <= TIMEOUT;
            o_timeout  <= 1'b1;
            o_valid_rx <= 1'b0;
          end else if (!sent_q && !i_tx_valid) begin
            o_valid_rx <= 1'b1;
            sent_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_sbinit.sv
// tb_rx_sbinit: directed stimulus for rx_sbinit checked every cycle against a
// milestone-based model of the handshake, plus hand-computed literal checks.
module tb_rx_sbinit;
  localparam int T = 20;
  logic       clk = 1'b0, rst_n, en, mv, txv, busy;
  logic [3:0] msg, enc;
  logic       v, e, to;
  int         n_chk = 0, n_fail = 0;

  rx_sbinit #(.SB_MSG_WIDTH(4), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_SBINIT_en(en),
    .i_decoded_msg_valid(mv), .i_decoded_SB_msg(msg),
    .i_tx_valid(txv), .i_falling_edge_busy(busy),
    .o_encoded_SB_msg_rx(enc), .o_valid_rx(v),
    .o_SBINIT_end_rx(e), .o_timeout(to)
  );

  always #5 clk = ~clk;

  // Model: tracks only what is observable -- whether done_req has arrived, the
  // request/ack of the response, and elapsed cycles since enable took effect.
  logic       m_on = 0, m_req = 0, m_sent = 0, m_valid = 0, m_end = 0, m_to = 0;
  logic [3:0] m_enc = 0;
  int         m_age = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !en) begin
      m_on <= 0; m_age <= 0; m_req <= 0; m_sent <= 0;
      m_valid <= 0; m_end <= 0; m_to <= 0; m_enc <= 0;
    end else if (!m_on) begin
      m_on <= 1; m_age <= 0;
    end else if (!m_end && !m_to) begin
      m_age <= m_age + 1;
      if (m_req && m_valid && busy) begin m_valid <= 0; m_end <= 1; end
      else if (!m_req && mv && msg == 4'd1) begin m_req <= 1; m_enc <= 4'd2; m_sent <= 0; end
      else if (m_age >= T - 1) begin m_to <= 1; m_valid <= 0; end
      else if (m_req && !m_sent && !txv) begin m_valid <= 1; m_sent <= 1; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_enc", 32'(enc), 32'(m_enc));
    chk("model_valid", 32'(v), 32'(m_valid));
    chk("model_end", 32'(e), 32'(m_end));
    chk("model_timeout", 32'(to), 32'(m_to));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] c);
    mv = 1; msg = c; cyc(1); mv = 0;
  endtask

  task automatic finish_hs(input string tag);
    cyc(1);
    chk({tag, "_valid_up"}, 32'(v), 1);
    busy = 1; cyc(1); busy = 0;
    chk({tag, "_end"}, 32'(e), 1);
    chk({tag, "_valid_down"}, 32'(v), 0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_enc0"}, 32'(enc), 0);
    chk({tag, "_valid0"}, 32'(v), 0);
    chk({tag, "_end0"}, 32'(e), 0);
    chk({tag, "_to0"}, 32'(to), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; en = 0; mv = 0; msg = 0; txv = 0; busy = 0;
    cyc(2);
    all_zero("reset");
    rst_n = 1; cyc(1);
    // normal flow
    en = 1; cyc(1);
    strobe(4'd3); cyc(3);
    strobe(4'd1);
    chk("norm_enc", 32'(enc), 2);
    chk("norm_valid_early", 32'(v), 0);
    cyc(1);
    chk("norm_valid", 32'(v), 1);
    cyc(9); busy = 1; cyc(1); busy = 0;
    chk("norm_end", 32'(e), 1);
    chk("norm_valid_off", 32'(v), 0);
    chk("norm_to", 32'(to), 0);
    strobe(4'd1); cyc(1);
    chk("end_ignores_req", 32'(v), 0);
    en = 0; cyc(1);
    all_zero("norm_dis");
    // lost Out_of_Reset
    en = 1; cyc(1);
    strobe(4'd1);
    chk("lost_oor_enc", 32'(enc), 2);
    finish_hs("lost_oor");
    en = 0; cyc(1);
    // arbitration with the transmit FSM
    en = 1; cyc(1);
    strobe(4'd3);
    txv = 1; strobe(4'd1);
    cyc(1); busy = 1; cyc(1); busy = 0;
    chk("arb_busy_ignored", 32'(e), 0);
    chk("arb_deferred", 32'(v), 0);
    cyc(3); txv = 0;
    chk("arb_still_low", 32'(v), 0);
    finish_hs("arb");
    en = 0; cyc(1);
    // timeout
    en = 1; cyc(20);
    chk("to_not_yet", 32'(to), 0);
    cyc(1);
    chk("to_fired", 32'(to), 1);
    strobe(4'd1); cyc(1);
    chk("to_ignores_req_enc", 32'(enc), 0);
    chk("to_ignores_req_valid", 32'(v), 0);
    en = 0; cyc(1);
    all_zero("to_dis");
    // disable mid-operation
    en = 1; cyc(1); strobe(4'd1); cyc(1);
    chk("mid_valid", 32'(v), 1);
    en = 0; cyc(1);
    all_zero("mid_dis");
    en = 1; cyc(1); strobe(4'd1);
    finish_hs("mid_again");
    // asynchronous reset mid-operation
    en = 0; cyc(1); en = 1; cyc(1); strobe(4'd1); cyc(1);
    chk("rst_valid", 32'(v), 1);
    #2 rst_n = 0;
    #1 all_zero("async_rst");
    @(negedge clk) rst_n = 1;
    cyc(1); strobe(4'd1);
    chk("rst_again_enc", 32'(enc), 2);
    finish_hs("rst_again");
    // noise in both waiting states
    en = 0; cyc(1); en = 1; cyc(1);
    strobe(4'd2); strobe(4'd0); msg = 4'd1; cyc(2);
    chk("noise_oor", 32'(enc), 0);
    strobe(4'd3); strobe(4'd2); strobe(4'd0); msg = 4'd1; cyc(2);
    chk("noise_req", 32'(enc), 0);
    strobe(4'd1);
    chk("noise_then_req", 32'(enc), 2);
    finish_hs("noise");
    en = 0; cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
